// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DIV_DEFAULT = 100;

    typedef logic [3:0] bcd9_t;
    typedef logic [2:0] bcd5_t;

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD digit counting 0..LIMIT; carry is combinational so a chain of
// digits all update on the same edge.
module bcd_digit #(
    parameter int LIMIT = 9,
    localparam int W    = $clog2(LIMIT + 1)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         carry
);

    logic [W-1:0] q_q, q_d;

    assign carry = inc && (q_q == W'(LIMIT));
    assign q     = q_q;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (inc)
            q_d = (q_q == W'(LIMIT)) ? '0 : q_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            q_q <= '0;
        else
            q_q <= q_d;
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: IDLE/RUN/PAUSE controller, divide-by-DIV prescaler and a
// four-digit BCD MM:SS counter that wraps at 59:59.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  start,
    input  logic  stop,
    input  logic  clear,
    output logic  tick,
    output logic  wrap,
    output logic  running,
    output bcd9_t sec_ones,
    output bcd5_t sec_tens,
    output bcd9_t min_ones,
    output bcd5_t min_tens
);

    localparam int            PW     = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic          tick_q, wrap_q, running_q;
    logic          advance, hit;
    logic          c_so, c_st, c_mo, c_mt;

    // Prescaler only moves on edges that neither enter nor leave RUN.
    assign advance = (state_q == RUN) && !stop && !clear;
    assign hit     = advance && (p_q == P_LAST);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        if (clear) begin
            state_d = IDLE;
            p_d     = '0;
        end else begin
            case (state_q)
                IDLE:    if (start && !stop) state_d = RUN;
                RUN:     if (stop)           state_d = PAUSE;
                PAUSE:   if (start && !stop) state_d = RUN;
                default:                     state_d = IDLE;
            endcase
            if (advance)
                p_d = hit ? '0 : p_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            p_q       <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            tick_q    <= hit;
            wrap_q    <= c_mt;
            running_q <= (state_d == RUN);
        end
    end

    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign running = running_q;

    bcd_digit #(.LIMIT(9)) u_sec_ones (
        .CLK(CLK), .RST(RST), .clr(clear), .inc(hit),  .q(sec_ones), .carry(c_so)
    );
    bcd_digit #(.LIMIT(5)) u_sec_tens (
        .CLK(CLK), .RST(RST), .clr(clear), .inc(c_so), .q(sec_tens), .carry(c_st)
    );
    bcd_digit #(.LIMIT(9)) u_min_ones (
        .CLK(CLK), .RST(RST), .clr(clear), .inc(c_st), .q(min_ones), .carry(c_mo)
    );
    bcd_digit #(.LIMIT(5)) u_min_tens (
        .CLK(CLK), .RST(RST), .clr(clear), .inc(c_mo), .q(min_tens), .carry(c_mt)
    );

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Stopwatch core that consumes the free-running system clock `CLK` and produces a BCD MM:SS time value for a display stage. A prescaler divides `CLK` by `DIV` to make a one-cycle `tick` strobe. A three-state controller (IDLE/RUN/PAUSE) gates the prescaler. Four chained BCD digit counters advance on each tick and wrap at 59:59.

## Interface
- `DIV`, default 100: `CLK` cycles per tick; legal range ≥ 2; prescaler width is `$clog2(DIV)`.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  level sampled each edge; moves IDLE or PAUSE to RUN.
- `stop`  in  1  level sampled each edge; moves RUN to PAUSE.
- `clear`  in  1  level sampled each edge; returns to IDLE from any state and zeroes the time.
- `tick`  out  1  one-cycle strobe, high in the same cycle the new time value appears.
- `wrap`  out  1  one-cycle strobe on the 59:59→00:00 transition; coincides with `tick`.
- `running`  out  1  high while in RUN.
- `sec_ones`  out  4  BCD digit, range 0–9.
- `sec_tens`  out  3  range 0–5.
- `min_ones`  out  4  range 0–9.
- `min_tens`  out  3  range 0–5.

## Operation
- All outputs are registered.
- On `RST`: state is IDLE, prescaler `p` is 0, all digits are 0, and `tick`, `wrap`, `running` are 0.
- Input priority on each edge: `RST` > `clear` > `stop` > `start`.
- State transitions:
  - IDLE: `start` → RUN.
  - RUN: `stop` → PAUSE.
  - PAUSE: `start` → RUN.
  - Any state: `clear` → IDLE, with `p` and all digits set to 0.
  - `start` while in RUN is ignored. `stop` while in IDLE or PAUSE is ignored.
- Prescaler advances only on an edge where the state is already RUN and no `stop`/`clear` is asserted. On such an edge:
  - if `p == DIV-1`: `p` ← 0, `tick` ← 1, time increments;
  - otherwise `p` ← `p+1`, `tick` ← 0.
- On the edge that enters or leaves RUN, `p` holds. PAUSE keeps the tick phase, so resuming continues the partial period.
- Time increment:
  - `sec_ones` 9→0 carries into `sec_tens`.
  - `sec_tens` 5→0 carries into `min_ones`.
  - `min_ones` 9→0 carries into `min_tens`.
  - `min_tens` 5→0, with all lower digits also wrapping, asserts `wrap`. Counting continues in RUN.
- Digits never take illegal BCD values (A–F, or tens > 5).
- `tick` and `wrap` are 0 in every cycle where no increment occurred, including all IDLE/PAUSE cycles.

## Timing
- `running` rises one cycle after the edge that samples `start` (registered from the next state).
- First tick after a `start` from IDLE: exactly `DIV` edges after the start edge. Subsequent ticks every `DIV` cycles.
- Resume from PAUSE with held `p = k`: next tick `DIV-1-k+1` edges after the resume edge.
- Same edge `stop` and `p == DIV-1`: stop wins. No tick, no increment, `p` holds at `DIV-1`. The tick fires on the first advancing edge after resume.
- `start` and `stop` together in RUN → PAUSE. `start` and `stop` together in PAUSE → stays PAUSE.
- `clear` on a tick edge: no increment, `tick`/`wrap` = 0, digits = 0.
- `RST` mid-count: identical to the reset values above on the next cycle.

## Structure
- Package `stopwatch_pkg`:
  - `state_t` enum {IDLE, RUN, PAUSE};
  - `DIV_DEFAULT` = 100;
  - `bcd9_t` (logic [3:0]);
  - `bcd5_t` (logic [2:0]).
- Sub-module `bcd_digit` (parameter `LIMIT`, width from `LIMIT`):
  - ports: `CLK`, `RST`, `clr`, `inc`, `q`, `carry`;
  - `carry = inc && q == LIMIT`, combinational.
  - Instantiate 4 times (LIMIT 9, 5, 9, 5), chaining each `carry` into the next `inc`.
- Top level holds the FSM, prescaler, and output registers.

## Test plan
All scenarios use `DIV = 4` and a 10 ns clock. "Edge N" counts rising edges after the start (or resume) edge.
- Reset: assert `RST` for 2 cycles mid-run at 00:07 → next cycle shows 00:00, `running`=0, `tick`=0; no ticks while idle for 20 cycles.
- Start: pulse `start` 1 cycle → `running`=1 the following cycle; `tick` at edges 4 and 8 → `sec_ones` = 1 then 2; `tick` width is exactly 1 cycle.
- Carries: run 10 ticks → 00:10; run 60 ticks → 01:00; run 600 ticks → 10:00.
- Wrap: run 3599 ticks → 59:59; next tick → 00:00 with `wrap`=1 for one cycle coincident with `tick`; 3601st tick → 00:01 with `wrap`=0.
- Pause/resume: `stop` when `p`=2 → 20 cycles with no `tick` and the time frozen; `start` → `tick` exactly 2 edges later. `stop` asserted on the `p=3` edge → no increment on that edge.
- Clear/priority: `clear` together with `start` in RUN → IDLE, 00:00, `running`=0. `start` and `stop` together in RUN → PAUSE. `clear` on a tick edge → `tick`=0, time 00:00.
